axi4lite_iir_coef_slave: RTL and testbench
==========================================

AXI4LITE_IIR_COEF_SLAVE -- requirements
Module: axi4lite_iir_coef_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width (8 word registers).
REQ-003 SHALL have port ACLK, in, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port ARESET, in, 1, reset, synchronous, active-high.
REQ-005 SHALL have AW channel ports: S_AXI_AWADDR in 5; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
REQ-006 SHALL have W channel ports: S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
REQ-007 SHALL have B channel ports: S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
REQ-008 SHALL have AR channel ports: S_AXI_ARADDR in 5; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
REQ-009 SHALL have R channel ports: S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-010 SHALL have coef_b0, coef_b1, coef_b2, coef_a1, coef_a2, out, 32 each, active coefficient bank to the IIR datapath.
REQ-011 SHALL have iir_enable out 1 (CTRL bit0), coef_update out 1 (one-cycle commit pulse), iir_busy in 1 (sampled into STATUS).

Function
REQ-012 Register map (word offsets): 0x00 CTRL, 0x04 STATUS (RO), 0x08 B0, 0x0C B1, 0x10 B2, 0x14 A1, 0x18 A2, 0x1C SCRATCH; address bits [1:0] ignored.
REQ-013 Writes to B0..A2 SHALL update the shadow bank only; reads of B0..A2 SHALL return the shadow bank.
REQ-014 CTRL write with WDATA[1]=1 SHALL copy shadow to active bank on the next edge and pulse coef_update for exactly one cycle; CTRL[1] reads 0.
REQ-015 STATUS SHALL read {30'b0, iir_busy, commit_pending}; commit_pending set by any shadow write, cleared by commit; STATUS writes ignored with OKAY.
REQ-016 Byte lanes SHALL be written only where WSTRB bit is 1.
REQ-017 Write FSM states W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP; AWREADY=WREADY=1 only in W_IDLE, WREADY only in W_WAIT_DATA, AWREADY only in W_WAIT_ADDR.
REQ-018 W_IDLE: AW+W same cycle -> write, W_RESP; AW only -> latch addr, W_WAIT_DATA; W only -> latch data/strb, W_WAIT_ADDR; both complete -> write, W_RESP.
REQ-019 BVALID SHALL assert the cycle after the register write and hold, BRESP stable, until BREADY; then W_IDLE.
REQ-020 Read FSM states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE; RDATA registered, RVALID asserted cycle after AR handshake, held stable until RREADY.
REQ-021 Read and write same register in same cycle SHALL return pre-write value; channels are independent.
REQ-022 CTRL commit and shadow write cannot coincide (single write port); a commit applies the shadow as of the commit cycle.

Reset
REQ-023 ARESET SHALL clear all registers, both banks, iir_enable, coef_update, commit_pending, BVALID, RVALID, RDATA to 0 and return both FSMs to IDLE, including mid-transaction; READY outputs 0 while ARESET high.

Configuration
REQ-024 With AXIL_IIR_SLVERR_EN defined, AW/AR to offsets beyond the map (none with 5-bit address; applies when C_S_AXI_ADDR_WIDTH>5) and writes to STATUS SHALL return SLVERR (2'b10); without it, all responses OKAY and unmapped reads return 0.

Structure
REQ-025 Shared package axi4lite_iir_pkg SHALL hold register offset constants, RESP codes, and write/read FSM state enums.
REQ-026 Sub-module axi4lite_iir_coef_bank SHALL hold shadow/active banks, strobe merge and commit logic.

Verification
REQ-027 Reset then read all 8 offsets -> all RDATA 0x00000000, RRESP OKAY.
REQ-028 Write B0=0x00010000 (AW+W same cycle), read B0 -> 0x00010000; coef_b0 stays 0; STATUS reads 0x1.
REQ-029 Write CTRL=0x3 -> coef_update high exactly one cycle, coef_b0=0x00010000, iir_enable=1, STATUS=0x0, CTRL reads 0x1.
REQ-030 AW 3 cycles before W, then W before AW on SCRATCH=0xA5A5A5A5 with WSTRB=4'b0011 -> SCRATCH reads 0x0000A5A5; one BVALID per write.
REQ-031 BREADY/RREADY held low 5 cycles -> BVALID/RVALID and data stable; no new AW/AR accepted meanwhile.
REQ-032 ARESET asserted during W_WAIT_DATA -> BVALID never asserts, next full write completes normally.

Source files
------------

// File: rtl/axi4lite_iir_pkg.sv
// axi4lite_iir_pkg: register word offsets, AXI response codes and FSM state types
// shared by the IIR coefficient slave and its coefficient bank.
package axi4lite_iir_pkg;
    // Word offsets (byte offset = index * 4)
    localparam logic [2:0] IDX_CTRL    = 3'd0;
    localparam logic [2:0] IDX_STATUS  = 3'd1;
    localparam logic [2:0] IDX_B0      = 3'd2;
    localparam logic [2:0] IDX_B1      = 3'd3;
    localparam logic [2:0] IDX_B2      = 3'd4;
    localparam logic [2:0] IDX_A1      = 3'd5;
    localparam logic [2:0] IDX_A2      = 3'd6;
    localparam logic [2:0] IDX_SCRATCH = 3'd7;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         N_COEF      = 5;
    typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    function automatic logic [31:0] strb_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        return m;
    endfunction
endpackage

// File: rtl/axi4lite_iir_coef_slave_if.sv
// axi4lite_iir_coef_slave_if: AXI4-Lite bus bundle with master/slave modports.
interface axi4lite_iir_coef_slave_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;
    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axi4lite_iir_coef_bank.sv
// axi4lite_iir_coef_bank: shadow/active coefficient banks with byte-strobe merge,
// commit copy, commit_pending flag and one-cycle update pulse.
module axi4lite_iir_coef_bank
    import axi4lite_iir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [2:0]               i_idx,
    input  logic [31:0]              i_data,
    input  logic [3:0]               i_strb,
    input  logic                     i_commit,
    output logic [N_COEF-1:0][31:0]  o_shadow,
    output logic [N_COEF-1:0][31:0]  o_active,
    output logic                     o_pending,
    output logic                     o_update
);
    logic [N_COEF-1:0][31:0] r_shadow, r_active;
    logic                    r_pending, r_update;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
            r_update  <= 1'b0;
        end else begin
            if (i_we) r_shadow[i_idx] <= strb_merge(r_shadow[i_idx], i_data, i_strb);
            if (i_commit) r_active <= r_shadow;
            r_pending <= i_we | (r_pending & ~i_commit);
            r_update  <= i_commit;
        end
    end
    assign o_shadow  = r_shadow;
    assign o_active  = r_active;
    assign o_pending = r_pending;
    assign o_update  = r_update;
endmodule

// File: rtl/axi4lite_iir_coef_slave.sv
// axi4lite_iir_coef_slave: AXI4-Lite register slave for IIR coefficients (shadow/active banks).
// Optional macro AXIL_IIR_SLVERR_EN: SLVERR on out-of-map accesses and STATUS writes.
module axi4lite_iir_coef_slave
    import axi4lite_iir_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic        ACLK,
    input  logic        ARESET,
    axi4lite_iir_coef_slave_if.slave s_axi,
    output logic [31:0] coef_b0,
    output logic [31:0] coef_b1,
    output logic [31:0] coef_b2,
    output logic [31:0] coef_a1,
    output logic [31:0] coef_a2,
    output logic        iir_enable,
    output logic        coef_update,
    input  logic        iir_busy
);
    function automatic logic addr_oob(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
        return (C_S_AXI_ADDR_WIDTH > 5) ? |(a >> 5) : 1'b0;
    endfunction
    w_state_t                        r_wstate, w_wstate_nxt;
    r_state_t                        r_rstate, w_rstate_nxt;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   r_awaddr, w_wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_wdata, w_wr_data, r_scratch, r_rdata, w_rd_val;
    logic [3:0]                      r_wstrb, w_wr_strb;
    logic [1:0]                      r_bresp, r_rresp;
    logic                            w_aw_hs, w_w_hs, w_ar_hs, w_wr_en, w_wr_ok, w_wr_oob, w_rd_oob;
    logic                            w_wr_err, w_rd_err, w_commit, w_bank_we, w_pending, r_enable;
    logic [2:0]                      w_wr_idx, w_rd_idx;
    logic [N_COEF-1:0][31:0]         w_shadow, w_active;
    logic                            w_unused;
    assign s_axi.S_AXI_AWREADY = !ARESET && (r_wstate == W_IDLE || r_wstate == W_WAIT_ADDR);
    assign s_axi.S_AXI_WREADY  = !ARESET && (r_wstate == W_IDLE || r_wstate == W_WAIT_DATA);
    assign s_axi.S_AXI_BVALID  = (r_wstate == W_RESP);
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign w_aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    assign w_w_hs  = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
    always_ff @(posedge ACLK) r_wstate <= ARESET ? W_IDLE : w_wstate_nxt;
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wr_en      = 1'b0;
        w_wr_addr    = w_aw_hs ? s_axi.S_AXI_AWADDR : r_awaddr;
        w_wr_data    = w_w_hs ? s_axi.S_AXI_WDATA : r_wdata;
        w_wr_strb    = w_w_hs ? s_axi.S_AXI_WSTRB : r_wstrb;
        case (r_wstate)
            W_IDLE: begin
                w_wr_en      = w_aw_hs && w_w_hs;
                w_wstate_nxt = w_wr_en ? W_RESP : w_aw_hs ? W_WAIT_DATA : w_w_hs ? W_WAIT_ADDR : W_IDLE;
            end
            W_WAIT_DATA: begin
                w_wr_en      = w_w_hs;
                w_wstate_nxt = w_w_hs ? W_RESP : W_WAIT_DATA;
            end
            W_WAIT_ADDR: begin
                w_wr_en      = w_aw_hs;
                w_wstate_nxt = w_aw_hs ? W_RESP : W_WAIT_ADDR;
            end
            default: w_wstate_nxt = s_axi.S_AXI_BREADY ? W_IDLE : W_RESP;
        endcase
    end
    assign w_wr_idx  = w_wr_addr[4:2];
    assign w_wr_oob  = addr_oob(w_wr_addr);
    assign w_wr_ok   = w_wr_en && !w_wr_oob;
    assign w_commit  = w_wr_ok && w_wr_idx == IDX_CTRL && w_wr_strb[0] && w_wr_data[1];
    assign w_bank_we = w_wr_ok && w_wr_idx >= IDX_B0 && w_wr_idx <= IDX_A2;
    assign w_rd_idx  = s_axi.S_AXI_ARADDR[4:2];
    assign w_rd_oob  = addr_oob(s_axi.S_AXI_ARADDR);
`ifdef AXIL_IIR_SLVERR_EN
    assign w_wr_err = w_wr_oob || w_wr_idx == IDX_STATUS;
    assign w_rd_err = w_rd_oob;
`else
    assign w_wr_err = 1'b0;
    assign w_rd_err = 1'b0;
`endif
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= RESP_OKAY;
            r_enable  <= 1'b0;
            r_scratch <= '0;
        end else begin
            if (w_aw_hs) r_awaddr <= s_axi.S_AXI_AWADDR;
            if (w_w_hs) begin
                r_wdata <= s_axi.S_AXI_WDATA;
                r_wstrb <= s_axi.S_AXI_WSTRB;
            end
            if (w_wr_en) r_bresp <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            if (w_wr_ok && w_wr_idx == IDX_CTRL && w_wr_strb[0]) r_enable <= w_wr_data[0];
            if (w_wr_ok && w_wr_idx == IDX_SCRATCH) r_scratch <= strb_merge(r_scratch, w_wr_data, w_wr_strb);
        end
    end
    axi4lite_iir_coef_bank u_bank (
        .clk      (ACLK),
        .rst      (ARESET),
        .i_we     (w_bank_we),
        .i_idx    (w_wr_idx - IDX_B0),
        .i_data   (w_wr_data),
        .i_strb   (w_wr_strb),
        .i_commit (w_commit),
        .o_shadow (w_shadow),
        .o_active (w_active),
        .o_pending(w_pending),
        .o_update (coef_update)
    );
    assign coef_b0    = w_active[0];
    assign coef_b1    = w_active[1];
    assign coef_b2    = w_active[2];
    assign coef_a1    = w_active[3];
    assign coef_a2    = w_active[4];
    assign iir_enable = r_enable;
    assign s_axi.S_AXI_ARREADY = !ARESET && r_rstate == R_IDLE;
    assign s_axi.S_AXI_RVALID  = (r_rstate == R_DATA);
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = r_rresp;
    assign w_ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    always_ff @(posedge ACLK) r_rstate <= ARESET ? R_IDLE : w_rstate_nxt;
    always_comb begin
        w_rstate_nxt = (r_rstate == R_IDLE) ? (w_ar_hs ? R_DATA : R_IDLE) : (s_axi.S_AXI_RREADY ? R_IDLE : R_DATA);
    end
    // Registered read sees pre-write values when a write lands in the same cycle
    always_comb begin
        w_rd_val = '0;
        case (w_rd_idx)
            IDX_CTRL:   w_rd_val = {31'b0, r_enable};
            IDX_STATUS: w_rd_val = {30'b0, iir_busy, w_pending};
            IDX_B0:     w_rd_val = w_shadow[0];
            IDX_B1:     w_rd_val = w_shadow[1];
            IDX_B2:     w_rd_val = w_shadow[2];
            IDX_A1:     w_rd_val = w_shadow[3];
            IDX_A2:     w_rd_val = w_shadow[4];
            default:    w_rd_val = r_scratch;
        endcase
        if (w_rd_oob) w_rd_val = '0;
    end
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_val;
            r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end
    assign w_unused = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, w_wr_addr[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_axi4lite_iir_coef_slave.sv
// tb_axi4lite_iir_coef_slave: directed AXI4-Lite bench with response scoreboards
// for the IIR coefficient slave.
module tb_axi4lite_iir_coef_slave;
    import axi4lite_iir_pkg::*;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        iir_busy = 1'b0;
    logic [31:0] coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
    logic        iir_enable, coef_update;
    int          n_pass = 0;
    int          n_total = 0;
    int          upd_cnt = 0;
    int          b_cnt = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
`ifdef AXIL_IIR_SLVERR_EN
    localparam logic [1:0] STATUS_WR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] STATUS_WR_RESP = RESP_OKAY;
`endif
    axi4lite_iir_coef_slave_if #(.ADDR_W(5), .DATA_W(32)) s_axi ();
    axi4lite_iir_coef_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .s_axi      (s_axi),
        .coef_b0    (coef_b0),
        .coef_b1    (coef_b1),
        .coef_b2    (coef_b2),
        .coef_a1    (coef_a1),
        .coef_a2    (coef_a2),
        .iir_enable (iir_enable),
        .coef_update(coef_update),
        .iir_busy   (iir_busy)
    );
    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) begin
        if (coef_update) upd_cnt <= upd_cnt + 1;
        if (s_axi.S_AXI_BVALID && s_axi.S_AXI_BREADY) b_cnt <= b_cnt + 1;
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] exp_resp);
        bit aw_done = 0, w_done = 0, aw_hs = 0, w_hs = 0, stable = 1, blocked = 1;
        int c = 0;
        int b0 = b_cnt;
        logic [1:0] resp0;
        s_axi.S_AXI_AWADDR = addr;
        s_axi.S_AXI_WDATA  = data;
        s_axi.S_AXI_WSTRB  = strb;
        s_axi.S_AXI_BREADY = 1'b0;
        while (!(aw_done && w_done) && c < 50) begin
            s_axi.S_AXI_AWVALID = !aw_done && c >= aw_dly;
            s_axi.S_AXI_WVALID  = !w_done && c >= w_dly;
            @(negedge ACLK);
            aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
            w_hs  = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
            @(posedge ACLK); #1;
            aw_done |= aw_hs;
            w_done  |= w_hs;
            c++;
        end
        s_axi.S_AXI_AWVALID = 1'b0;
        s_axi.S_AXI_WVALID  = 1'b0;
        check("wr_handshake", {30'b0, aw_done, w_done}, 32'h3);
        bq.push_back(exp_resp);
        c = 0;
        while (!s_axi.S_AXI_BVALID && c < 20) begin @(posedge ACLK); #1; c++; end
        check("b_latency", c, 0);
        resp0 = s_axi.S_AXI_BRESP;
        s_axi.S_AXI_AWVALID = (b_dly > 0);
        for (int k = 0; k < b_dly; k++) begin
            @(negedge ACLK);
            if (s_axi.S_AXI_AWREADY || s_axi.S_AXI_WREADY) blocked = 0;
            @(posedge ACLK); #1;
            if (!s_axi.S_AXI_BVALID || s_axi.S_AXI_BRESP !== resp0) stable = 0;
        end
        s_axi.S_AXI_AWVALID = 1'b0;
        if (b_dly > 0) check("b_stall", {30'b0, stable, blocked}, 32'h3);
        s_axi.S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        s_axi.S_AXI_BREADY = 1'b0;
        check("bresp", resp0, bq.pop_front());
        check("b_count", b_cnt - b0, 1);
        check("bvalid_drop", s_axi.S_AXI_BVALID, 0);
    endtask
    task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp, input int r_dly, input string tag);
        bit hs = 0, stable = 1, blocked = 1;
        int c = 0;
        logic [31:0] d0;
        logic [1:0]  r0;
        logic [33:0] e;
        rq.push_back({RESP_OKAY, exp});
        s_axi.S_AXI_RREADY  = 1'b0;
        s_axi.S_AXI_ARADDR  = addr;
        s_axi.S_AXI_ARVALID = 1'b1;
        while (!hs && c < 20) begin
            @(negedge ACLK);
            hs = s_axi.S_AXI_ARREADY;
            @(posedge ACLK); #1;
            c++;
        end
        s_axi.S_AXI_ARVALID = 1'b0;
        check("ar_handshake", {31'b0, hs}, 32'h1);
        c = 0;
        while (!s_axi.S_AXI_RVALID && c < 20) begin @(posedge ACLK); #1; c++; end
        check("r_latency", c, 0);
        d0 = s_axi.S_AXI_RDATA;
        r0 = s_axi.S_AXI_RRESP;
        s_axi.S_AXI_ARVALID = (r_dly > 0);
        for (int k = 0; k < r_dly; k++) begin
            @(negedge ACLK);
            if (s_axi.S_AXI_ARREADY) blocked = 0;
            @(posedge ACLK); #1;
            if (!s_axi.S_AXI_RVALID || s_axi.S_AXI_RDATA !== d0 || s_axi.S_AXI_RRESP !== r0) stable = 0;
        end
        s_axi.S_AXI_ARVALID = 1'b0;
        if (r_dly > 0) check("r_stall", {30'b0, stable, blocked}, 32'h3);
        s_axi.S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        s_axi.S_AXI_RREADY = 1'b0;
        e = rq.pop_front();
        check(tag, d0, e[31:0]);
        check("rresp", {30'b0, r0}, {30'b0, e[33:32]});
        check("rvalid_drop", s_axi.S_AXI_RVALID, 0);
    endtask
    initial begin
        int u0;
        bit saw_b;
        s_axi.S_AXI_AWADDR = '0; s_axi.S_AXI_AWPROT = '0; s_axi.S_AXI_AWVALID = 1'b0;
        s_axi.S_AXI_WDATA = '0; s_axi.S_AXI_WSTRB = '0; s_axi.S_AXI_WVALID = 1'b0;
        s_axi.S_AXI_BREADY = 1'b0; s_axi.S_AXI_ARADDR = '0; s_axi.S_AXI_ARPROT = '0;
        s_axi.S_AXI_ARVALID = 1'b0; s_axi.S_AXI_RREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        check("ready_in_reset", {29'b0, s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_ARREADY}, 0);
        check("valid_in_reset", {30'b0, s_axi.S_AXI_BVALID, s_axi.S_AXI_RVALID}, 0);
        check("outs_in_reset", {30'b0, iir_enable, coef_update}, 0);
        check("coef_b0_reset", coef_b0, 0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        for (int i = 0; i < 8; i++) axi_read(5'(i * 4), 32'h0, 0, "reset_read");
        axi_write(5'h08, 32'h0001_0000, 4'hF, 0, 0, 0, RESP_OKAY);
        axi_read(5'h08, 32'h0001_0000, 0, "b0_shadow");
        check("coef_b0_before_commit", coef_b0, 0);
        axi_read(5'h04, 32'h1, 0, "status_pending");
        u0 = upd_cnt;
        axi_write(5'h00, 32'h3, 4'hF, 0, 0, 0, RESP_OKAY);
        repeat (3) @(posedge ACLK);
        #1;
        check("update_pulses", upd_cnt - u0, 1);
        check("coef_b0_active", coef_b0, 32'h0001_0000);
        check("iir_enable", {31'b0, iir_enable}, 1);
        axi_read(5'h04, 32'h0, 0, "status_committed");
        axi_read(5'h00, 32'h1, 0, "ctrl_read");
        axi_write(5'h1C, 32'hA5A5_A5A5, 4'b0011, 0, 3, 0, RESP_OKAY);
        axi_read(5'h1C, 32'h0000_A5A5, 0, "scratch_aw_first");
        axi_write(5'h1C, 32'hA5A5_A5A5, 4'b0011, 3, 0, 0, RESP_OKAY);
        axi_read(5'h1C, 32'h0000_A5A5, 0, "scratch_w_first");
        axi_write(5'h1E, 32'h5A5A_5A5A, 4'b1100, 0, 0, 0, RESP_OKAY);
        axi_read(5'h1C, 32'h5A5A_A5A5, 0, "scratch_upper");
        axi_write(5'h0C, 32'h1234_5678, 4'hF, 0, 0, 5, RESP_OKAY);
        axi_read(5'h0C, 32'h1234_5678, 5, "b1_stall");
        check("coef_b1_not_committed", coef_b1, 0);
        iir_busy = 1'b1;
        axi_read(5'h04, 32'h3, 0, "status_busy");
        iir_busy = 1'b0;
        axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, STATUS_WR_RESP);
        axi_read(5'h04, 32'h1, 0, "status_after_write");
        s_axi.S_AXI_AWADDR  = 5'h10;
        s_axi.S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        check("aw_ready_midreset", {31'b0, s_axi.S_AXI_AWREADY}, 1);
        @(posedge ACLK); #1;
        s_axi.S_AXI_AWVALID = 1'b0;
        ARESET = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        check("ready_mid_reset", {29'b0, s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_ARREADY}, 0);
        ARESET = 1'b0;
        saw_b = 0;
        s_axi.S_AXI_WDATA  = 32'hDEAD_BEEF;
        s_axi.S_AXI_WSTRB  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(posedge ACLK); #1;
            if (s_axi.S_AXI_BVALID) saw_b = 1;
        end
        check("no_bvalid_after_reset", {31'b0, saw_b}, 0);
        check("coef_b0_cleared", coef_b0, 0);
        check("enable_cleared", {31'b0, iir_enable}, 0);
        axi_read(5'h08, 32'h0, 0, "b0_cleared");
        axi_write(5'h10, 32'hCAFE_F00D, 4'hF, 0, 0, 0, RESP_OKAY);
        axi_read(5'h10, 32'hCAFE_F00D, 0, "b2_after_reset");
        axi_write(5'h00, 32'h2, 4'hF, 0, 0, 0, RESP_OKAY);
        @(posedge ACLK); #1;
        check("coef_b2_active", coef_b2, 32'hCAFE_F00D);
        check("enable_off", {31'b0, iir_enable}, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
